// File: rtl/ps2_scan_decoder.sv
// PS/2 scan-code decoder: folds E0/F0 prefixes into make/break events and queues them in a FWFT FIFO.
// Optional repeat-make suppression is compiled in with `define PS2_TYPEMATIC_FILTER_EN.
module ps2_scan_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       fifo_full,
    output logic       overflow,
    input  logic       clr_overflow,
    output logic       err_tick
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    state_t state;

    logic is_e0;
    logic is_f0;
    logic is_err;
    logic ev_ext;
    logic ev_brk;
    logic evt_formed;
    logic push;
    logic pop;
    logic wr_en;
    logic drop;

    logic [9:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [9:0]       head;

    assign is_e0      = (rx_data == 8'hE0);
    assign is_f0      = (rx_data == 8'hF0);
    assign is_err     = (rx_data == 8'h00) || (rx_data == 8'hFF);
    assign ev_ext     = (state == S_EXT) || (state == S_EXT_BRK);
    assign ev_brk     = (state == S_BRK) || (state == S_EXT_BRK);
    assign evt_formed = rx_done_tick && !is_e0 && !is_f0 && !is_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            err_tick <= 1'b0;
        end else begin
            err_tick <= rx_done_tick && is_err;
            if (rx_done_tick) begin
                if (is_e0) begin
                    state <= S_EXT;
                end else if (is_f0) begin
                    case (state)
                        S_IDLE:  state <= S_BRK;
                        S_EXT:   state <= S_EXT_BRK;
                        default: state <= state;
                    endcase
                end else begin
                    state <= S_IDLE;
                end
            end
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       held_valid;
    logic [7:0] held_code;
    logic       held_ext;
    logic       held_match;

    // A key held down auto-repeats its make code; only the first make and the break get through.
    assign held_match = held_valid && (held_code == rx_data) && (held_ext == ev_ext);
    assign push       = evt_formed && !(held_match && !ev_brk);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            held_valid <= 1'b0;
            held_code  <= 8'h00;
            held_ext   <= 1'b0;
        end else if (evt_formed) begin
            if (!ev_brk && !held_match) begin
                held_valid <= 1'b1;
                held_code  <= rx_data;
                held_ext   <= ev_ext;
            end else if (ev_brk && held_match) begin
                held_valid <= 1'b0;
            end
        end
    end
`else
    assign push = evt_formed;
`endif

    assign pop   = evt_valid && evt_ready;
    assign wr_en = push && (!fifo_full || pop);
    assign drop  = push && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {ev_ext, ev_brk, rx_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_en && !pop) begin
                count <= count + (PTR_W+1)'(1);
            end else if (pop && !wr_en) begin
                count <= count - (PTR_W+1)'(1);
            end
            // A drop in the same cycle as the clear wins so no loss goes unreported.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    assign head      = mem[rd_ptr];
    assign evt_valid = (count != '0);
    assign fifo_full = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign evt_code  = evt_valid ? head[7:0] : 8'h00;
    assign evt_break = evt_valid ? head[8]   : 1'b0;
    assign evt_ext   = evt_valid ? head[9]   : 1'b0;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed self-checking bench for ps2_scan_decoder (FIFO_DEPTH=4).
// Expectations follow PS2_TYPEMATIC_FILTER_EN when the bench is compiled with it.
module tb_ps2_scan_decoder;

    logic       clk;
    logic       reset_n;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       evt_ready;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       fifo_full;
    logic       overflow;
    logic       clr_overflow;
    logic       err_tick;

    int checks   = 0;
    int failures = 0;

    ps2_scan_decoder #(.FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .evt_ready    (evt_ready),
        .evt_valid    (evt_valid),
        .evt_code     (evt_code),
        .evt_ext      (evt_ext),
        .evt_break    (evt_break),
        .fifo_full    (fifo_full),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .err_tick     (err_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Presents one received byte for a single cycle; returns 1 time unit after the capturing edge.
    task automatic applyStimulus(input logic [7:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
    endtask

    task automatic popCheck(input string tag, input logic [7:0] code, input logic ext, input logic brk);
        checkOutput({tag, "_valid"}, 8'(evt_valid), 8'h01);
        checkOutput({tag, "_code"},  evt_code,      code);
        checkOutput({tag, "_ext"},   8'(evt_ext),   8'(ext));
        checkOutput({tag, "_brk"},   8'(evt_break), 8'(brk));
        evt_ready = 1'b1;
        @(posedge clk);
        #1;
        evt_ready = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        evt_ready    = 1'b0;
        clr_overflow = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid",    8'(evt_valid), 8'h00);
        checkOutput("rst_code",     evt_code,      8'h00);
        checkOutput("rst_ext",      8'(evt_ext),   8'h00);
        checkOutput("rst_brk",      8'(evt_break), 8'h00);
        checkOutput("rst_full",     8'(fifo_full), 8'h00);
        checkOutput("rst_overflow", 8'(overflow),  8'h00);
        checkOutput("rst_err",      8'(err_tick),  8'h00);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Ready with an empty FIFO must not disturb anything
        evt_ready = 1'b1;
        @(posedge clk);
        #1;
        evt_ready = 1'b0;
        checkOutput("empty_pop_valid", 8'(evt_valid), 8'h00);

        // Single make code, one-cycle latency
        rx_data      = 8'h1C;
        rx_done_tick = 1'b1;
        #1;
        checkOutput("make_valid_in_tick", 8'(evt_valid), 8'h00);
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
        popCheck("make", 8'h1C, 1'b0, 1'b0);
        checkOutput("make_drained", 8'(evt_valid), 8'h00);

        // Extended break E0 F0 75
        applyStimulus(8'hE0);
        checkOutput("ext_pre_valid", 8'(evt_valid), 8'h00);
        applyStimulus(8'hF0);
        checkOutput("extbrk_pre_valid", 8'(evt_valid), 8'h00);
        applyStimulus(8'h75);
        popCheck("extbrk", 8'h75, 1'b1, 1'b1);
        applyStimulus(8'h1C);
        popCheck("after_extbrk_idle", 8'h1C, 1'b0, 1'b0);
        checkOutput("extbrk_drained", 8'(evt_valid), 8'h00);

        // Fill, overflow, clear races
        applyStimulus(8'h15);
        applyStimulus(8'h1D);
        applyStimulus(8'h24);
        checkOutput("fill3_full", 8'(fifo_full), 8'h00);
        applyStimulus(8'h2D);
        checkOutput("fill4_full", 8'(fifo_full), 8'h01);
        checkOutput("fill4_ovf",  8'(overflow),  8'h00);
        applyStimulus(8'h2C);
        checkOutput("drop_ovf",  8'(overflow),  8'h01);
        checkOutput("drop_full", 8'(fifo_full), 8'h01);
        clr_overflow = 1'b1;
        applyStimulus(8'h33);
        clr_overflow = 1'b0;
        checkOutput("drop_with_clr_ovf", 8'(overflow), 8'h01);
        clr_overflow = 1'b1;
        @(posedge clk);
        #1;
        clr_overflow = 1'b0;
        checkOutput("clr_ovf", 8'(overflow), 8'h00);

        // Push and pop together while full: occupancy holds, nothing dropped
        evt_ready = 1'b1;
        applyStimulus(8'h2C);
        evt_ready = 1'b0;
        checkOutput("pushpop_full", 8'(fifo_full), 8'h01);
        checkOutput("pushpop_ovf",  8'(overflow),  8'h00);
        popCheck("q0", 8'h1D, 1'b0, 1'b0);
        checkOutput("pop_not_full", 8'(fifo_full), 8'h00);
        popCheck("q1", 8'h24, 1'b0, 1'b0);
        popCheck("q2", 8'h2D, 1'b0, 1'b0);
        popCheck("q3", 8'h2C, 1'b0, 1'b0);
        checkOutput("fifo_drained", 8'(evt_valid), 8'h00);

        // Error byte between F0 and a code drops the break prefix
        applyStimulus(8'hF0);
        applyStimulus(8'hFF);
        checkOutput("err_pulse",    8'(err_tick),  8'h01);
        checkOutput("err_no_event", 8'(evt_valid), 8'h00);
        applyStimulus(8'h1C);
        checkOutput("err_pulse_end", 8'(err_tick), 8'h00);
        popCheck("after_err", 8'h1C, 1'b0, 1'b0);
        applyStimulus(8'h00);
        checkOutput("err00_pulse", 8'(err_tick), 8'h01);
        checkOutput("err00_no_event", 8'(evt_valid), 8'h00);

        // Auto-repeat sequence
        applyStimulus(8'h1C);
        applyStimulus(8'h1C);
        applyStimulus(8'h1C);
        applyStimulus(8'hF0);
        applyStimulus(8'h1C);
        popCheck("rep_make0", 8'h1C, 1'b0, 1'b0);
`ifdef PS2_TYPEMATIC_FILTER_EN
        popCheck("rep_break", 8'h1C, 1'b0, 1'b1);
`else
        popCheck("rep_make1", 8'h1C, 1'b0, 1'b0);
        popCheck("rep_make2", 8'h1C, 1'b0, 1'b0);
        popCheck("rep_break", 8'h1C, 1'b0, 1'b1);
`endif
        checkOutput("rep_drained", 8'(evt_valid), 8'h00);

        // Reset mid-prefix with events queued
        applyStimulus(8'h1C);
        applyStimulus(8'h2D);
        applyStimulus(8'hE0);
        checkOutput("prerst_valid", 8'(evt_valid), 8'h01);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 8'(evt_valid), 8'h00);
        checkOutput("midrst_code",  evt_code,      8'h00);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(8'h1C);
        popCheck("postrst", 8'h1C, 1'b0, 1'b0);
        checkOutput("postrst_drained", 8'(evt_valid), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_scan_decoder.md
PS2_SCAN_DECODER -- requirements
Module: ps2_scan_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, event FIFO depth (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rx_done_tick  input  1  one-cycle strobe, rx_data valid this cycle.
REQ-005 SHALL have port rx_data  input  8  received PS2 byte from the upstream receiver.
REQ-006 SHALL have port evt_ready  input  1  consumer accepts the head event.
REQ-007 SHALL have port evt_valid  output  1  FIFO non-empty, head event presented.
REQ-008 SHALL have port evt_code  output  8  head event scan code.
REQ-009 SHALL have port evt_ext  output  1  head event carried E0 prefix.
REQ-010 SHALL have port evt_break  output  1  head event is a key release (F0 prefix).
REQ-011 SHALL have port fifo_full  output  1  FIFO holds FIFO_DEPTH events.
REQ-012 SHALL have port overflow  output  1  sticky, an event was dropped due to full FIFO.
REQ-013 SHALL have port clr_overflow  input  1  synchronous clear of overflow.
REQ-014 SHALL have port err_tick  output  1  one-cycle pulse on discarded error byte.

Function
REQ-015 SHALL run a prefix FSM with states S_IDLE, S_EXT, S_BRK, S_EXT_BRK, advancing only on cycles with rx_done_tick=1.
REQ-016 SHALL on byte 0xE0 go to S_EXT from any state, discarding any partial prefix.
REQ-017 SHALL on byte 0xF0 go S_IDLE->S_BRK, S_EXT->S_EXT_BRK, and hold in S_BRK/S_EXT_BRK.
REQ-018 SHALL on bytes 0x00 or 0xFF pulse err_tick next cycle, return to S_IDLE, emit no event.
REQ-019 SHALL on any other byte form an event {code=rx_data, ext=state in S_EXT/S_EXT_BRK, break=state in S_BRK/S_EXT_BRK} and return to S_IDLE.
REQ-020 SHALL write a formed event into the FIFO on the rising edge ending the rx_done_tick cycle; evt_valid rises the following cycle (1-cycle latency).
REQ-021 SHALL present the FIFO head combinationally on evt_code/evt_ext/evt_break (first-word fall-through); outputs are don't-care when evt_valid=0 but SHALL be 0 after reset.
REQ-022 SHALL pop the head on cycles with evt_valid=1 and evt_ready=1; evt_ready with FIFO empty has no effect.
REQ-023 SHALL, on simultaneous push and pop, accept both with occupancy unchanged, including when full.
REQ-024 SHALL, on push when full with no pop, drop the new event, keep FIFO contents, and set overflow.
REQ-025 SHALL hold overflow until clr_overflow=1; a new drop in the same cycle as clr_overflow leaves overflow=1.
REQ-026 SHALL use wrapping read/write pointers with an occupancy counter of log2(FIFO_DEPTH)+1 bits; fifo_full = (count==FIFO_DEPTH).

Reset
REQ-027 SHALL on reset_n=0 asynchronously force FSM to S_IDLE, empty the FIFO, and drive evt_valid, evt_code, evt_ext, evt_break, fifo_full, overflow, err_tick to 0.
REQ-028 SHALL discard any partial prefix and queued events when reset asserts mid-sequence; the first byte after release decodes from S_IDLE.

Configuration
REQ-029 SHALL, with macro PS2_TYPEMATIC_FILTER_EN defined, keep a held-key register (valid, code, ext): make event equal to held key is dropped (no push, no overflow); other make is pushed and becomes held; break matching held clears valid; all breaks pushed.
REQ-030 SHALL, without PS2_TYPEMATIC_FILTER_EN, push every formed event and instantiate no held-key register.

Verification
REQ-031 SHALL cover: bytes 0x1C -> one event {0x1C,ext0,brk0}, evt_valid high 1 cycle after tick.
REQ-032 SHALL cover: bytes E0,F0,0x75 -> one event {0x75,ext1,brk1}; FSM back in S_IDLE.
REQ-033 SHALL cover: 5 make codes 0x15,0x1D,0x24,0x2D,0x2C with evt_ready=0, depth 4 -> fifo_full=1, overflow=1, pops yield 0x15,0x1D,0x24,0x2D.
REQ-034 SHALL cover: byte 0xFF between F0 and 0x1C -> err_tick pulse, event {0x1C,brk0}.
REQ-035 SHALL cover: with filter, 0x1C,0x1C,0x1C,F0,0x1C -> exactly two events (make, break); without filter -> four events.
REQ-036 SHALL cover: reset_n low after E0 with 2 events queued -> evt_valid=0, next byte 0x1C yields {0x1C,ext0}.
